// File: rtl/vc_pop_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : vc_pop_fifo
//  Description : Input buffer ahead of a 1-to-2 demux. Pops the head word only
//                when the downstream FIFO selected by the head's selector bit
//                is not almost-full, and presents the popped word one cycle
//                after the pop decision. Strict in-order, no bypass.
//  Revision    : 1.0 - initial release
// ============================================================================
module vc_pop_fifo #(
    parameter int DATA_SIZE  = 6,
    parameter int ADDR_SIZE  = 3,
    parameter int BIT_SELECT = 1
) (
    input  logic                 clk,
    input  logic                 reset_L,
    input  logic                 push_i,
    input  logic [DATA_SIZE-1:0] data_in_i,
    input  logic                 almost_full0_i,
    input  logic                 almost_full1_i,
    input  logic [ADDR_SIZE:0]   umbral_af_i,
    input  logic [ADDR_SIZE:0]   umbral_ae_i,
    output logic                 en_pop_o,
    output logic [DATA_SIZE-1:0] data_out_o,
    output logic [ADDR_SIZE:0]   count_o,
    output logic                 full_o,
    output logic                 empty_o,
    output logic                 almost_full_o,
    output logic                 almost_empty_o,
    output logic                 error_o
);

    localparam int               c_entries = 2 ** ADDR_SIZE;
    localparam logic [ADDR_SIZE:0] c_depth = {1'b1, {ADDR_SIZE{1'b0}}};

    // Storage and pointers
    logic [DATA_SIZE-1:0] mem_q [c_entries];
    logic [ADDR_SIZE-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_SIZE-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_SIZE:0]   count_q,  count_d;
    logic                 en_pop_q, en_pop_d;
    logic [DATA_SIZE-1:0] data_out_q, data_out_d;
    logic                 error_q,  error_d;

    // Decode of the pre-edge state
    logic [DATA_SIZE-1:0] w_head;
    logic                 w_sel;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_pop;
    logic                 w_push_ok;

    assign w_head    = mem_q[rd_ptr_q];
    assign w_sel     = w_head[DATA_SIZE-BIT_SELECT];
    assign w_full    = (count_q == c_depth);
    assign w_empty   = (count_q == '0);
    // The head only leaves when the FIFO it is routed to can accept it;
    // anything behind a blocked head waits, keeping order intact.
    assign w_pop     = !w_empty && (w_sel ? !almost_full1_i : !almost_full0_i);
    assign w_push_ok = push_i && !w_full;

    // Next-state computation for pointers, occupancy, output stage and error
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        en_pop_d   = 1'b0;
        data_out_d = '0;
        // A push into a full FIFO is lost even if a pop frees a slot this edge.
        error_d    = error_q | (push_i & w_full);

        if (w_push_ok) begin
            wr_ptr_d = wr_ptr_q + ADDR_SIZE'(1);
        end

        if (w_pop) begin
            rd_ptr_d   = rd_ptr_q + ADDR_SIZE'(1);
            en_pop_d   = 1'b1;
            data_out_d = w_head;
        end

        case ({w_push_ok, w_pop})
            2'b10:   count_d = count_q + (ADDR_SIZE+1)'(1);
            2'b01:   count_d = count_q - (ADDR_SIZE+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Control and output registers, cleared asynchronously
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            en_pop_q   <= 1'b0;
            data_out_q <= '0;
            error_q    <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            en_pop_q   <= en_pop_d;
            data_out_q <= data_out_d;
            error_q    <= error_d;
        end
    end

    // Word storage; contents are don't-care after reset so no reset term
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            mem_q[wr_ptr_q] <= data_in_i;
        end
    end

    assign en_pop_o       = en_pop_q;
    assign data_out_o     = data_out_q;
    assign count_o        = count_q;
    assign full_o         = w_full;
    assign empty_o        = w_empty;
    assign almost_full_o  = (count_q >= umbral_af_i);
    assign almost_empty_o = (count_q <= umbral_ae_i) && !w_empty;
    assign error_o        = error_q;

endmodule
`default_nettype wire

// File: tb/tb_vc_pop_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vc_pop_fifo
//  Description : Self-checking bench for vc_pop_fifo. A queue-based model
//                follows the buffer; a compare process checks every output on
//                each falling edge, and directed scenarios pin literal values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vc_pop_fifo;

    localparam int DS = 6;
    localparam int AS = 3;
    localparam int BS = 1;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          reset_L;
    logic          push_i;
    logic [DS-1:0] data_in_i;
    logic          almost_full0_i;
    logic          almost_full1_i;
    logic [AS:0]   umbral_af_i;
    logic [AS:0]   umbral_ae_i;
    logic          en_pop_o;
    logic [DS-1:0] data_out_o;
    logic [AS:0]   count_o;
    logic          full_o;
    logic          empty_o;
    logic          almost_full_o;
    logic          almost_empty_o;
    logic          error_o;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [DS-1:0] m_q [$];
    logic          m_en   = 1'b0;
    logic [DS-1:0] m_dout = '0;
    logic          m_err  = 1'b0;

    vc_pop_fifo #(.DATA_SIZE(DS), .ADDR_SIZE(AS), .BIT_SELECT(BS)) dut (
        .clk            (clk),
        .reset_L        (reset_L),
        .push_i         (push_i),
        .data_in_i      (data_in_i),
        .almost_full0_i (almost_full0_i),
        .almost_full1_i (almost_full1_i),
        .umbral_af_i    (umbral_af_i),
        .umbral_ae_i    (umbral_ae_i),
        .en_pop_o       (en_pop_o),
        .data_out_o     (data_out_o),
        .count_o        (count_o),
        .full_o         (full_o),
        .empty_o        (empty_o),
        .almost_full_o  (almost_full_o),
        .almost_empty_o (almost_empty_o),
        .error_o        (error_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: a plain queue of stored words
    initial begin
        forever begin
            @(posedge clk or negedge reset_L);
            if (!reset_L) begin
                m_q.delete();
                m_en   = 1'b0;
                m_dout = '0;
                m_err  = 1'b0;
            end else begin
                bit            was_full;
                bit            can_pop;
                logic [DS-1:0] h;
                was_full = (m_q.size() == DEPTH);
                can_pop  = 1'b0;
                if (m_q.size() != 0) begin
                    h       = m_q[0];
                    can_pop = h[DS-BS] ? !almost_full1_i : !almost_full0_i;
                end
                if (can_pop) begin
                    m_dout = m_q.pop_front();
                    m_en   = 1'b1;
                end else begin
                    m_en   = 1'b0;
                    m_dout = '0;
                end
                if (push_i) begin
                    if (was_full) m_err = 1'b1;
                    else          m_q.push_back(data_in_i);
                end
            end
        end
    end

    // Compare every output against the model mid-cycle
    always @(negedge clk) begin
        int n;
        n = m_q.size();
        chk("count",        32'(count_o),        32'(n));
        chk("empty",        32'(empty_o),        32'(n == 0));
        chk("full",         32'(full_o),         32'(n == DEPTH));
        chk("almost_full",  32'(almost_full_o),  32'(n >= int'(umbral_af_i)));
        chk("almost_empty", 32'(almost_empty_o), 32'((n <= int'(umbral_ae_i)) && (n != 0)));
        chk("en_pop",       32'(en_pop_o),       32'(m_en));
        chk("data_out",     32'(data_out_o),     32'(m_dout));
        chk("error",        32'(error_o),        32'(m_err));
    end

    // One clock cycle: drive inputs, take the edge, settle 2 time units after it
    task automatic cyc(input logic p, input logic [DS-1:0] d);
        push_i    = p;
        data_in_i = d;
        @(posedge clk);
        #2;
    endtask

    initial begin
        reset_L        = 1'b0;
        push_i         = 1'b0;
        data_in_i      = '0;
        almost_full0_i = 1'b0;
        almost_full1_i = 1'b0;
        umbral_af_i    = 4'd6;
        umbral_ae_i    = 4'd2;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_count", 32'(count_o), 32'd0);
        chk("rst_empty", 32'(empty_o), 32'd1);
        chk("rst_en",    32'(en_pop_o), 32'd0);
        reset_L = 1'b1;

        // Basic flow: 0x05, 0x25, 0x0A pushed back to back
        cyc(1'b1, 6'h05);
        chk("bf_en0", 32'(en_pop_o), 32'd0);
        cyc(1'b1, 6'h25);
        chk("bf_en1", 32'(en_pop_o), 32'd1);
        chk("bf_d1",  32'(data_out_o), 32'h05);
        cyc(1'b1, 6'h0A);
        chk("bf_d2",  32'(data_out_o), 32'h25);
        cyc(1'b0, 6'h00);
        chk("bf_d3",  32'(data_out_o), 32'h0A);
        chk("bf_en3", 32'(en_pop_o), 32'd1);
        cyc(1'b0, 6'h00);
        chk("bf_en4", 32'(en_pop_o), 32'd0);

        // Per-destination stall: head routes to port 1, which is almost full
        almost_full1_i = 1'b1;
        cyc(1'b1, 6'h21);
        cyc(1'b1, 6'h01);
        cyc(1'b0, 6'h00);
        chk("st_count", 32'(count_o), 32'd2);
        chk("st_en",    32'(en_pop_o), 32'd0);
        almost_full1_i = 1'b0;
        cyc(1'b0, 6'h00);
        chk("st_d0", 32'(data_out_o), 32'h21);
        cyc(1'b0, 6'h00);
        chk("st_d1", 32'(data_out_o), 32'h01);
        cyc(1'b0, 6'h00);
        chk("st_en_end", 32'(en_pop_o), 32'd0);

        // Fill and overflow
        almost_full0_i = 1'b1;
        almost_full1_i = 1'b1;
        for (int i = 0; i < 9; i++) begin
            cyc(1'b1, DS'(i * 7 + 3));
            if (i == 7) chk("fill_full", 32'(full_o), 32'd1);
            if (i == 7) chk("fill_err_pre", 32'(error_o), 32'd0);
        end
        chk("ovf_err",   32'(error_o), 32'd1);
        chk("ovf_count", 32'(count_o), 32'd8);
        almost_full0_i = 1'b0;
        almost_full1_i = 1'b0;
        repeat (10) cyc(1'b0, 6'h00);
        chk("drain_err",   32'(error_o), 32'd1);
        chk("drain_empty", 32'(empty_o), 32'd1);

        // Threshold flags while filling 0 -> 8, then drain
        umbral_af_i    = 4'd6;
        umbral_ae_i    = 4'd2;
        almost_full0_i = 1'b1;
        almost_full1_i = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            cyc(1'b1, DS'($urandom));
            chk("flg_ae", 32'(almost_empty_o), 32'(k >= 1 && k <= 2));
            chk("flg_af", 32'(almost_full_o),  32'(k >= 6));
        end
        almost_full0_i = 1'b0;
        almost_full1_i = 1'b0;
        repeat (10) cyc(1'b0, 6'h00);

        // Steady occupancy of 4 with push+pop every cycle across pointer wrap
        almost_full0_i = 1'b1;
        almost_full1_i = 1'b1;
        repeat (4) cyc(1'b1, DS'($urandom));
        almost_full0_i = 1'b0;
        almost_full1_i = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, DS'($urandom_range(1, 63)));
            chk("wrap_count", 32'(count_o), 32'd4);
        end
        repeat (6) cyc(1'b0, 6'h00);

        // Reset mid-burst, asserted between edges
        almost_full0_i = 1'b1;
        almost_full1_i = 1'b1;
        repeat (5) cyc(1'b1, DS'($urandom_range(1, 63)));
        push_i  = 1'b0;
        reset_L = 1'b0;
        #1;
        chk("mrst_count", 32'(count_o),    32'd0);
        chk("mrst_empty", 32'(empty_o),    32'd1);
        chk("mrst_en",    32'(en_pop_o),   32'd0);
        chk("mrst_dout",  32'(data_out_o), 32'd0);
        chk("mrst_err",   32'(error_o),    32'd0);
        @(posedge clk);
        #2;
        reset_L        = 1'b1;
        almost_full0_i = 1'b0;
        almost_full1_i = 1'b0;

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            almost_full0_i = ($urandom_range(0, 99) < 30);
            almost_full1_i = ($urandom_range(0, 99) < 30);
            if ($urandom_range(0, 49) == 0) begin
                umbral_af_i = 4'($urandom_range(1, 8));
                umbral_ae_i = 4'($urandom_range(0, 8));
            end
            if ($urandom_range(0, 399) == 0) begin
                reset_L = 1'b0;
                @(posedge clk);
                #2;
                reset_L = 1'b1;
            end
            cyc(($urandom_range(0, 99) < 60), DS'($urandom));
        end
        cyc(1'b0, 6'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
